// File: rtl/clock_ratio_pkg.sv
// Shared types and constants for clock_ratio_detector.
package clock_ratio_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACQUIRE,
    ST_LOCKED
  } state_e;

  // Default TIMEOUT is this many expected input periods.
  localparam int unsigned TIMEOUT_MULT = 4;

  // Bits needed to hold any value in 0..max_val.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/edge_sync.sv
// Input conditioning for clock_ratio_detector: registers sig_i (through a
// 2-flop synchronizer when CLOCK_RATIO_DETECTOR_SYNC_EN is defined, a single
// register otherwise), then an edge register producing rise/fall pulses.
module edge_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic sig_i,
  output logic rise_o,
  output logic fall_o
);

  logic s_q;
  logic s_d_q;

`ifdef CLOCK_RATIO_DETECTOR_SYNC_EN
  logic meta_q;

  // Two-flop synchronizer for an asynchronous input
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      meta_q <= 1'b0;
      s_q    <= 1'b0;
    end else begin
      meta_q <= sig_i;
      s_q    <= meta_q;
    end
  end
`else
  // Single register for an input already synchronous to clk_i
  always_ff @(posedge clk_i) begin
    if (rst_i) s_q <= 1'b0;
    else       s_q <= sig_i;
  end
`endif

  // Edge register: previous conditioned level
  always_ff @(posedge clk_i) begin
    if (rst_i) s_d_q <= 1'b0;
    else       s_d_q <= s_q;
  end

  // Rise/fall pulses, high for the single cycle the new level first appears
  always_comb begin
    rise_o = s_q & ~s_d_q;
    fall_o = ~s_q & s_d_q;
  end

endmodule

// File: rtl/clock_ratio_detector.sv
// Measures a slow square wave in clk_in cycles, reports half-period and
// period, and flags lock to the expected CLK_IN/CLK_OUT ratio and timeout.
// Build option: CLOCK_RATIO_DETECTOR_SYNC_EN adds a 2-flop input synchronizer.
module clock_ratio_detector
  import clock_ratio_pkg::*;
#(
  parameter int unsigned CLK_IN     = 100,
  parameter int unsigned CLK_OUT    = 10,
  parameter int unsigned TOL        = 1,
  parameter int unsigned LOCK_COUNT = 4,
  parameter int unsigned TIMEOUT    = TIMEOUT_MULT * (CLK_IN / CLK_OUT),
  localparam int unsigned CW        = cnt_width(TIMEOUT)
) (
  input  logic          clk_in,
  input  logic          rst,
  input  logic          sig_in,
  output logic [CW-1:0] half_period,
  output logic [CW:0]   period,
  output logic          valid,
  output logic          locked,
  output logic          timeout
);

  localparam int unsigned HALF = (CLK_IN / CLK_OUT) / 2;
  localparam int unsigned GW   = cnt_width(LOCK_COUNT);
  localparam int unsigned LO_I = (TOL >= HALF) ? 0 : HALF - TOL;
  // Upper bound kept below TIMEOUT so a saturated count is never good.
  localparam int unsigned HI_I = (HALF + TOL >= TIMEOUT) ? TIMEOUT - 1 : HALF + TOL;

  localparam logic [CW-1:0] TMO     = CW'(TIMEOUT);
  localparam logic [CW-1:0] GOOD_LO = CW'(LO_I);
  localparam logic [CW-1:0] GOOD_HI = CW'(HI_I);
  localparam logic [GW-1:0] LOCK_N  = GW'(LOCK_COUNT);

  logic          rise, fall, sig_edge;
  state_e        state_q;
  logic [CW-1:0] hcnt_q, hcnt_d;
  logic [GW-1:0] good_cnt_q, good_cnt_inc;
  logic [CW-1:0] high_len_q;
  logic          high_vld_q;
  logic          good;
  logic [CW:0]   period_sum;
  logic [CW-1:0] half_period_q;
  logic [CW:0]   period_q;
  logic          valid_q, locked_q, timeout_q;

  edge_sync u_edge_sync (
    .clk_i  (clk_in),
    .rst_i  (rst),
    .sig_i  (sig_in),
    .rise_o (rise),
    .fall_o (fall)
  );

  // Level counter next value, capture quality and period sum
  always_comb begin
    sig_edge = rise | fall;
    hcnt_d   = hcnt_q;
    if (sig_edge)           hcnt_d = CW'(1);
    else if (hcnt_q != TMO) hcnt_d = hcnt_q + 1'b1;
    good         = (hcnt_q >= GOOD_LO) && (hcnt_q <= GOOD_HI);
    good_cnt_inc = (good_cnt_q == LOCK_N) ? good_cnt_q : good_cnt_q + 1'b1;
    // On a rising edge the running count is the low half just completed.
    period_sum   = {1'b0, hcnt_q} + {1'b0, high_len_q};
  end

  // Measurement FSM with registered outputs; an edge takes priority over timeout
  always_ff @(posedge clk_in) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      hcnt_q        <= '0;
      good_cnt_q    <= '0;
      high_len_q    <= '0;
      high_vld_q    <= 1'b0;
      half_period_q <= '0;
      period_q      <= '0;
      valid_q       <= 1'b0;
      locked_q      <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      hcnt_q  <= hcnt_d;
      valid_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (sig_edge) begin
            state_q    <= ST_ACQUIRE;
            timeout_q  <= 1'b0;
            good_cnt_q <= '0;
            high_vld_q <= 1'b0;
          end else if (hcnt_q == TMO) begin
            timeout_q <= 1'b1;
          end
        end
        default: begin
          if (sig_edge) begin
            half_period_q <= hcnt_q;
            if (fall) begin
              high_len_q <= hcnt_q;
              high_vld_q <= 1'b1;
            end
            if (rise && high_vld_q) begin
              period_q <= period_sum;
              valid_q  <= 1'b1;
            end
            if (good) begin
              good_cnt_q <= good_cnt_inc;
              if (good_cnt_inc == LOCK_N) begin
                state_q  <= ST_LOCKED;
                locked_q <= 1'b1;
              end
            end else begin
              good_cnt_q <= '0;
              state_q    <= ST_ACQUIRE;
              locked_q   <= 1'b0;
            end
          end else if (hcnt_q == TMO) begin
            state_q    <= ST_IDLE;
            timeout_q  <= 1'b1;
            locked_q   <= 1'b0;
            good_cnt_q <= '0;
            high_vld_q <= 1'b0;
          end
        end
      endcase
    end
  end

  assign half_period = half_period_q;
  assign period      = period_q;
  assign valid       = valid_q;
  assign locked      = locked_q;
  assign timeout     = timeout_q;

endmodule
